// File: rtl/gcore_pkg.sv
// Shared definitions for the GCore accumulator core: opcodes, phase FSM
// states and the ALU operation encoding used by the execute phase.
package gcore_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDM = 4'h1;
   localparam logic [3:0] OP_LDI = 4'h2;
   localparam logic [3:0] OP_STM = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_SHL = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_BZ  = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hC;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [3:0] {
      ALU_KEEP,
      ALU_MEM,
      ALU_IMM,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SHL4
   } alu_op_t;

   // Map an opcode to the ALU operation that produces the next ACC value.
   function automatic alu_op_t decode_alu(input logic [3:0] opcode);
      case (opcode)
         OP_LDM:  return ALU_MEM;
         OP_LDI:  return ALU_IMM;
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_SHL:  return ALU_SHL4;
         default: return ALU_KEEP;
      endcase
   endfunction

   // Only the two-operand arithmetic/logic ops touch the zero flag.
   function automatic logic updates_zero(input logic [3:0] opcode);
      return (opcode >= OP_ADD) && (opcode <= OP_XOR);
   endfunction

endpackage

// File: rtl/gcore_dmem.sv
// Data memory: one register per word, combinational read, synchronous
// write, and an asynchronous clear that zeroes every word.
module gcore_dmem
   import gcore_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] words [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DATA_W-1:0] word_reg;

         // Each word loads wdata only when it is the addressed target.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               word_reg <= '0;
            end else if (we && (addr == ADDR_W'(gi))) begin
               word_reg <= wdata;
            end
         end

         assign words[gi] = word_reg;
      end
   endgenerate

   assign rdata = words[addr];

endmodule

// File: rtl/gcore_core.sv
// GCore accumulator CPU: single clock, four-phase FSM per instruction
// (fetch, decode, execute, write-back), run/step control and HALT.
module gcore_core
   import gcore_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int OPND_W  = 4,
   parameter int PC_W    = 8,
   parameter int INSTR_W = 4 + OPND_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [DATA_W-1:0]  acc_out,
   output logic [PC_W-1:0]    pc_out,
   output logic               zero_out,
   output logic               halted,
   output logic               instr_done
);

   state_t              state_reg;
   state_t              state_next;
   logic [PC_W-1:0]     pc_reg;
   logic [DATA_W-1:0]   acc_reg;
   logic                zero_reg;
   logic [INSTR_W-1:0]  ir_reg;
   logic [DATA_W-1:0]   alu_reg;
   logic                step_q_reg;

   logic [3:0]          opcode;
   logic [OPND_W-1:0]   opnd;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_we;
   logic [DATA_W-1:0]   alu_result;
   logic                step_edge;
   logic                jump_taken;
   logic [PC_W-1:0]     jump_target;

   assign opcode      = ir_reg[INSTR_W-1:OPND_W];
   assign opnd        = ir_reg[OPND_W-1:0];
   assign step_edge   = step & ~step_q_reg;
   assign mem_we      = (state_reg == S_EXEC) && (opcode == OP_STM);
   assign jump_taken  = (opcode == OP_JMP) || ((opcode == OP_BZ) && zero_reg);
   // Size cast truncates or zero-extends the memory word to the PC width.
   assign jump_target = PC_W'(mem_rdata);

   gcore_dmem #(
      .DATA_W (DATA_W),
      .ADDR_W (OPND_W)
   ) u_dmem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .addr  (opnd),
      .wdata (acc_reg),
      .rdata (mem_rdata)
   );

   // ALU: next accumulator value for the decoded opcode; opcodes that do
   // not load ACC pass the current value through.
   always_comb begin
      alu_result = acc_reg;
      case (decode_alu(opcode))
         ALU_MEM:  alu_result = mem_rdata;
         ALU_IMM:  alu_result = DATA_W'(opnd);
         ALU_ADD:  alu_result = acc_reg + mem_rdata;
         ALU_SUB:  alu_result = acc_reg - mem_rdata;
         ALU_AND:  alu_result = acc_reg & mem_rdata;
         ALU_OR:   alu_result = acc_reg | mem_rdata;
         ALU_XOR:  alu_result = acc_reg ^ mem_rdata;
         ALU_SHL4: alu_result = {acc_reg[DATA_W-5:0], 4'b0000};
         default:  alu_result = acc_reg;
      endcase
   end

   // Phase sequencing; fetch waits for run or a fresh step edge.
   always_comb begin
      state_next = state_reg;
      instr_done = 1'b0;
      case (state_reg)
         S_FETCH: begin
            if (run || step_edge) begin
               state_next = S_DECODE;
            end
         end
         S_DECODE: state_next = S_EXEC;
         S_EXEC:   state_next = S_WB;
         S_WB: begin
            instr_done = 1'b1;
            state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
         end
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   // Architectural state: IR latched in decode, ALU result in execute,
   // ACC/zero/PC committed in write-back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= S_FETCH;
         pc_reg     <= '0;
         acc_reg    <= '0;
         zero_reg   <= 1'b0;
         ir_reg     <= '0;
         alu_reg    <= '0;
         step_q_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         step_q_reg <= step;
         case (state_reg)
            S_DECODE: ir_reg <= imem_rdata;
            S_EXEC:   alu_reg <= alu_result;
            S_WB: begin
               acc_reg <= alu_reg;
               if (updates_zero(opcode)) begin
                  zero_reg <= (alu_reg == '0);
               end
               pc_reg <= jump_taken ? jump_target : pc_reg + PC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = pc_reg;
   assign pc_out    = pc_reg;
   assign acc_out   = acc_reg;
   assign zero_out  = zero_reg;
   assign halted    = (state_reg == S_HALT);

endmodule

// File: doc/gcore_core.md
Name: gcore_core

Overview:
- Parametrised single-clock accumulator CPU core; the next generation of the GCore 8-bit datapath.
- Replaces the multi-phase derived clocks (pc/opram/mem/acc/alu) with one clock and an internal phase FSM.
- Generalises data, operand and PC widths; adds HALT, run/single-step control and a debug status interface.
- Instruction memory is external (synchronous ROM/RAM); data memory is internal.

Parameters:
- DATA_W, 8, accumulator/data-memory word width (>=8)
- OPND_W, 4, operand field width; data memory depth = 2**OPND_W
- PC_W, 8, program counter width; instruction address space = 2**PC_W
- INSTR_W, 4+OPND_W, instruction width (derived; do not override)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- run  in  1  level: 1 = free-run, 0 = stepped
- step  in  1  rising edge advances one instruction when run=0
- imem_addr  out  PC_W  instruction fetch address
- imem_rdata  in  INSTR_W  instruction word, valid one cycle after imem_addr
- acc_out  out  DATA_W  accumulator value
- pc_out  out  PC_W  current PC
- zero_out  out  1  zero flag
- halted  out  1  core in HALT
- instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (rst=0, async): PC=0, ACC=0, zero=0, IR=0, all data memory words=0, FSM=S_FETCH, step edge register=0. All outputs 0.
- FSM: S_FETCH -> S_DECODE -> S_EXEC -> S_WB -> S_FETCH; 4 cycles per instruction; S_HALT is absorbing until reset.
- S_FETCH: imem_addr=PC. Advance only if run=1, or run=0 and a step rising edge is detected (step & ~step_q) in this cycle; otherwise hold.
- Step edges arriving outside S_FETCH are lost. Step is ignored while run=1.
- S_DECODE: IR<=imem_rdata. Opcode = IR[INSTR_W-1:OPND_W]; operand a = IR[OPND_W-1:0].
- S_EXEC: data memory read is combinational on a. ALU result is registered. STM writes mem[a]<=ACC at the end of S_EXEC.
- S_WB: ACC/zero/PC update; instr_done=1 for this cycle only. HLT retires (instr_done=1) and then enters S_HALT instead of S_FETCH.
- Opcodes (hex):
  - 0 NOP
  - 1 LDM: ACC=mem[a]
  - 2 LDI: ACC=zext(a)
  - 3 STM: mem[a]=ACC
  - 4 ADD: ACC=ACC+mem[a]
  - 5 SUB: ACC=ACC-mem[a]
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 SHL4: ACC={ACC[DATA_W-5:0],4'b0}
  - A JMP: PC=mem[a][PC_W-1:0], zero-extended if DATA_W<PC_W
  - B BZ: jump as JMP if zero=1
  - C HLT
  - D-F: NOP
- Arithmetic is modulo 2**DATA_W; there is no carry flag.
- zero is updated only by opcodes 4-8 (result==0); all other opcodes keep it.
- PC: PC+1 modulo 2**PC_W (0xFF->0x00 at PC_W=8) unless a jump is taken.
- S_HALT: imem_addr holds the HLT's PC+1; run/step are ignored.
- run dropping mid-instruction: the current instruction completes; the core stops in S_FETCH.

Decomposition:
- Package gcore_pkg holds: opcode localparams (OP_NOP..OP_HLT), the FSM state enum (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT), and the ALU op encoding.
- One sub-module: gcore_dmem (2**OPND_W x DATA_W, async read, sync write, async active-low clear).
- ALU and decode stay in gcore_core.

Test Plan:
- Reset mid-instruction: rst low during S_EXEC of an STM 0x5 -> outputs 0, mem[5] stays 0, the next fetch is from 0x00.
- Run program at 0x00: LDI 7; STM 2; LDI 3; ADD 2; HLT -> acc_out=0x0A, zero=0. instr_done pulses exactly 5 times, 4 cycles apart. halted=1 at cycle 20.
- SUB to zero and BZ: LDI 4; STM 1; SUB 1; BZ 1 -> zero=1 and the branch is taken to mem[1]=4 (pc_out=4). A variant with nonzero ACC falls through to PC+1.
- Step mode, run=0: no step gives PC stable for 50 cycles. Three step pulses give exactly 3 instr_done pulses. A 10-cycle-wide step pulse gives one instruction.
- PC wrap at PC_W=8: NOP at 0xFF -> next imem_addr=0x00.
- Parameter sweep DATA_W=16, OPND_W=6: SHL4 of 0x1234 -> 0x2340; ADD 0xFFFF+1 -> 0x0000 and zero=1.
